// File: rtl/simd_lane_alu_pipe.sv
// simd_lane_alu_pipe: pipelined packed-SIMD ALU (8/16/32/64-bit lanes) with saturation sticky flag.
// Define SIMD_MUL_EN to build the per-lane multiplier (func 15); otherwise func 15 returns zero.
`ifndef PTYPE_INT
`define PTYPE_INT 0
`endif
module simd_lane_alu_pipe #(
    parameter int PIPE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [12:0] operation,
    input  logic [67:0] A,
    input  logic [67:0] B,
    input  logic        clr_sat,
    output logic [67:0] res,
    output logic        out_valid,
    output logic        sat_sticky
);
    // Returns {clamped, result}; each lane is widened to 66 signed bits so one
    // comparator serves both signed and unsigned lanes.
    function automatic logic [64:0] lane_alu(input logic [6:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] m, x, y, r;
        logic signed [65:0] xs, ys, s, hi, lo;
        logic sat;
        int w;
        w = 8 << op[5:4];
        m = (64'd1 << w) - 64'd1;
        hi = op[6] ? {3'b0, m[63:1]} : {2'b0, m};
        lo = ~hi & {66{op[6]}};
        r = '0;
        sat = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i * w < 64) begin
                x = (a >> (i * w)) & m;
                y = (b >> (i * w)) & m;
                xs = {2'b0, x} | ((op[6] && x > (m >> 1)) ? ~{2'b0, m} : 66'd0);
                ys = {2'b0, y} | ((op[6] && y > (m >> 1)) ? ~{2'b0, m} : 66'd0);
                case (op[3:0])
                    4'd0, 4'd2: s = xs + ys;
                    4'd1, 4'd3: s = xs - ys;
                    4'd4:       s = xs < ys ? xs : ys;
                    4'd5:       s = xs > ys ? xs : ys;
                    4'd6:       s = {66{xs == ys}};
                    4'd7:       s = {66{xs > ys}};
`ifdef SIMD_MUL_EN
                    4'd15:      s = xs * ys;
`endif
                    default:    s = '0;
                endcase
                if (op[3:1] == 3'd1 && (s > hi || s < lo)) begin
                    sat = 1'b1;
                    s = s > hi ? hi : lo;
                end
                r = r | ((s[63:0] & m) << (i * w));
            end
        end
        return {sat, r};
    endfunction

    logic [PIPE_DEPTH-1:0] v;
    logic [6:0]            op0;
    logic [63:0]           a0, b0;
    logic [64:0]           c;
    logic [64:0]           pr [1:PIPE_DEPTH-1];
    logic                  unused;

    assign unused = ^{operation[12:7], A[67:65], A[32], B[67:65], B[32]};

    always_comb begin
        c = lane_alu(op0, a0, b0);
        case (op0[3:0])
            4'd8:    c = {1'b0, a0 & b0};
            4'd9:    c = {1'b0, a0 | b0};
            4'd10:   c = {1'b0, a0 ^ b0};
            4'd11:   c = {1'b0, a0 & ~b0};
            4'd12:   c = {1'b0, ~(a0 | b0)};
            4'd13:   c = {1'b0, ~(a0 ^ b0)};
            4'd14:   c = {1'b0, b0};
            default: c = c;
        endcase
    end

    always_ff @(posedge clk) begin
        v <= rst ? '0 : {v[PIPE_DEPTH-2:0], en};
        op0 <= operation[6:0];
        a0 <= {A[64:33], A[31:0]};
        b0 <= {B[64:33], B[31:0]};
        pr[1] <= c;
        for (int k = 2; k < PIPE_DEPTH; k++) pr[k] <= pr[k-1];
        sat_sticky <= rst ? 1'b0 : (v[PIPE_DEPTH-1] && pr[PIPE_DEPTH-1][64]) ? 1'b1 : clr_sat ? 1'b0 : sat_sticky;
    end

    assign out_valid = v[PIPE_DEPTH-1];
    assign res = out_valid ? {2'd`PTYPE_INT, 1'b0, pr[PIPE_DEPTH-1][63:32], 1'b0, pr[PIPE_DEPTH-1][31:0]} : 68'd0;
endmodule

// File: tb/tb_simd_lane_alu_pipe.sv
// tb_simd_lane_alu_pipe: directed + sweep stimulus checked every cycle against a lane-level arithmetic model.
`ifndef PTYPE_INT
`define PTYPE_INT 0
`endif
module tb_simd_lane_alu_pipe;
    localparam int D = 3;
    logic        clk = 1'b0;
    logic        rst, en, clr_sat, out_valid, sat_sticky;
    logic [12:0] operation;
    logic [67:0] A, B, res;
    int          checks = 0, errors = 0, cyc = 1, nout = 0, n0;
    bit          run = 1'b0, msticky = 1'b0;
    bit          ev [0:4095];
    bit          es [0:4095];
    logic [63:0] er [0:4095];

    always #5 clk = ~clk;

    simd_lane_alu_pipe #(.PIPE_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .en(en), .operation(operation), .A(A), .B(B),
        .clr_sat(clr_sat), .res(res), .out_valid(out_valid), .sat_sticky(sat_sticky)
    );

    task automatic chk(input string name, input logic [67:0] got, input logic [67:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Lane values as plain integers: wrap, clamp, compare, multiply by arithmetic.
    function automatic logic [64:0] model(input logic [6:0] op, input logic [63:0] a, input logic [63:0] b);
        int L;
        logic [63:0] r, mk, ua, ub;
        logic sat;
        logic signed [129:0] md, va, vb, v, hi, lo;
        L = 8 << op[5:4];
        mk = (64'd1 << L) - 64'd1;
        md = 130'sd1 <<< L;
        hi = op[6] ? md / 2 - 1 : md - 1;
        lo = op[6] ? -(md / 2) : 0;
        r = 0;
        sat = 0;
        case (op[3:0])
            4'd8:  return {1'b0, a & b};
            4'd9:  return {1'b0, a | b};
            4'd10: return {1'b0, a ^ b};
            4'd11: return {1'b0, a & ~b};
            4'd12: return {1'b0, ~(a | b)};
            4'd13: return {1'b0, ~(a ^ b)};
            4'd14: return {1'b0, b};
            default: ;
        endcase
        for (int i = 0; i < 64 / L; i++) begin
            ua = (a >> (i * L)) & mk;
            ub = (b >> (i * L)) & mk;
            va = $signed({66'd0, ua});
            vb = $signed({66'd0, ub});
            if (va > hi) va = va - md;
            if (vb > hi) vb = vb - md;
            case (op[3:0])
                4'd0, 4'd2: v = va + vb;
                4'd1, 4'd3: v = va - vb;
                4'd4: v = (va < vb) ? va : vb;
                4'd5: v = (va > vb) ? va : vb;
                4'd6: v = (va == vb) ? -1 : 0;
                4'd7: v = (va > vb) ? -1 : 0;
`ifdef SIMD_MUL_EN
                4'd15: v = va * vb;
`endif
                default: v = 0;
            endcase
            if (op[3:0] == 4'd2 || op[3:0] == 4'd3) begin
                if (v > hi) begin v = hi; sat = 1; end
                else if (v < lo) begin v = lo; sat = 1; end
            end
            r = r | ((v[63:0] & mk) << (i * L));
        end
        return {sat, r};
    endfunction

    function automatic logic [67:0] pack(input logic [63:0] d);
        return {3'($urandom), d[63:32], 1'($urandom), d[31:0]};
    endfunction

    always @(posedge clk) begin : mdl
        int e;
        logic [64:0] m;
        e = cyc;
        if (rst) begin
            msticky = 0;
            for (int k = 0; k <= D; k++) ev[e+k] = 0;
        end else begin
            if (ev[e-1] && es[e-1]) msticky = 1;
            else if (clr_sat) msticky = 0;
            if (en) begin
                m = model(operation[6:0], {A[64:33], A[31:0]}, {B[64:33], B[31:0]});
                ev[e+D-1] = 1;
                er[e+D-1] = m[63:0];
                es[e+D-1] = m[64];
            end
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin : cmp
        int s;
        if (run) begin
            s = cyc - 1;
            if (out_valid) nout++;
            chk("out_valid", 68'(out_valid), 68'(ev[s]));
            chk("res", res, ev[s] ? {2'd`PTYPE_INT, 1'b0, er[s][63:32], 1'b0, er[s][31:0]} : 68'd0);
            chk("sat_sticky", 68'(sat_sticky), 68'(msticky));
        end
    end

    task automatic issue(input logic [6:0] op, input logic [63:0] a, input logic [63:0] b, input logic clr);
        @(negedge clk);
        en = 1'b1;
        operation = {6'($urandom), op};
        A = pack(a);
        B = pack(b);
        clr_sat = clr;
    endtask

    task automatic idle(input int n, input logic clr);
        repeat (n) begin
            @(negedge clk);
            en = 1'b0;
            clr_sat = clr;
            A = pack({$urandom, $urandom});
            B = pack({$urandom, $urandom});
        end
    endtask

    task automatic pin(input string name, input logic [6:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input logic exps);
        logic [64:0] m;
        m = model(op, a, b);
        chk(name, 68'(m), 68'({exps, exp}));
        issue(op, a, b, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b1; clr_sat = 1'b0; operation = '0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        run = 1'b1;
        chk("reset_res", res, 68'd0);
        chk("reset_sticky", 68'(sat_sticky), 68'd0);
        @(negedge clk);
        rst = 1'b0; en = 1'b0;
        pin("r031_addsat_u8", 7'h02, {8{8'hF0}}, {8{8'h20}}, {8{8'hFF}}, 1'b1);
        idle(D + 1, 1'b0);
        chk("r031_sticky", 68'(sat_sticky), 68'd1);
        pin("r032_subsat_s16", 7'h53, {4{16'h8000}}, {4{16'h0001}}, {4{16'h8000}}, 1'b1);
        idle(D + 1, 1'b0);
        issue(7'h10, 64'd1, 64'd2, 1'b1);
        idle(1, 1'b0);
        chk("r032_cleared", 68'(sat_sticky), 68'd0);
        issue(7'h02, {8{8'hF0}}, {8{8'h20}}, 1'b0);
        idle(3, 1'b1);
        idle(1, 1'b0);
        chk("set_wins", 68'(sat_sticky), 68'd1);
        pin("r033_add32", 7'h20, 64'hFFFFFFFF_FFFFFFFF, 64'd1, 64'hFFFFFFFF_00000000, 1'b0);
        pin("r034_cmpgt_s8", 7'h47, {8{8'h01}}, {8{8'hFF}}, {8{8'hFF}}, 1'b0);
        pin("r034_cmpgt_u8", 7'h07, {8{8'h01}}, {8{8'hFF}}, 64'd0, 1'b0);
`ifdef SIMD_MUL_EN
        pin("r036_mul16", 7'h1F, {4{16'h0102}}, {4{16'h0100}}, {4{16'h0200}}, 1'b0);
`else
        pin("r036_mul16", 7'h1F, {4{16'h0102}}, {4{16'h0100}}, 64'd0, 1'b0);
`endif
        pin("addsat_s64", 7'h72, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
        pin("min_s8", 7'h44, 64'h807F0001FF102030, 64'h7F80010001201030, 64'h80800000FF101030, 1'b0);
        pin("andn", 7'h0B, {4{16'hF0F0}}, {4{16'hFF00}}, {4{16'h00F0}}, 1'b0);
        pin("sub_u8", 7'h01, 64'd0, {8{8'h01}}, {8{8'hFF}}, 1'b0);
        idle(D + 1, 1'b1);
        n0 = nout;
        issue(7'h00, 64'd1, 64'd1, 1'b0);
        issue(7'h00, 64'd2, 64'd2, 1'b0);
        idle(1, 1'b0);
        issue(7'h00, 64'd3, 64'd3, 1'b0);
        issue(7'h00, 64'd4, 64'd4, 1'b0);
        @(negedge clk);
        en = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(D + 2, 1'b0);
        chk("r035_emerged", 68'(nout - n0), 68'd2);
        for (int f = 0; f < 16; f++)
            for (int sz = 0; sz < 4; sz++)
                issue({1'($urandom), 2'(sz), 4'(f)}, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
        idle(D + 2, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/simd_lane_alu_pipe.md
SIMD_LANE_ALU_PIPE -- requirements
Module: simd_lane_alu_pipe

Interface
REQ-001 SHALL have parameter PIPE_DEPTH, default 2, legal 2..4: posedges from accepted input to res/out_valid.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port en  input  1  issue strobe; one operation accepted per posedge with en=1.
REQ-005 SHALL have port operation  input  13  [3:0] func, [5:4] lane size (00=8, 01=16, 10=32, 11=64 bit), [6] signed, [12:7] ignored.
REQ-006 SHALL have port A  input  68  operand; data = {A[64:33],A[31:0]}, all other bits ignored.
REQ-007 SHALL have port B  input  68  operand; same packing as A.
REQ-008 SHALL have port clr_sat  input  1  clears sat_sticky.
REQ-009 SHALL have port res  output  68  {2'd`ptype_int,1'b0,R[63:32],1'b0,R[31:0]} when out_valid, else all zero.
REQ-010 SHALL have port out_valid  output  1  res valid this cycle.
REQ-011 SHALL have port sat_sticky  output  1  sticky flag: some lane of a saturating op clamped.

Function
REQ-012 SHALL be fully pipelined: the op accepted at edge N appears on res with out_valid=1 for exactly one cycle, after edge N+PIPE_DEPTH-1; back-to-back ops SHALL emerge in order, one per cycle.
REQ-013 SHALL NOT stall; no backpressure; en=0 creates a bubble (out_valid=0 in the matching cycle).
REQ-014 SHALL treat the 64-bit data as 64/L independent lanes, L = lane size; no carry crosses lane boundaries.
REQ-015 func 0 add, 1 sub: modulo 2^L per lane.
REQ-016 func 2 addsat, 3 subsat: signed clamps to [-2^(L-1), 2^(L-1)-1], unsigned to [0, 2^L-1].
REQ-017 func 4 min, 5 max: per lane, signedness from operation[6].
REQ-018 func 6 cmpeq, 7 cmpgt (A>B, signedness from [6]): lane result all-ones if true, else all-zeros.
REQ-019 func 8 and, 9 or, 10 xor, 11 A&~B, 12 nor, 13 xnor, 14 mov B: bitwise, lane size irrelevant.
REQ-020 func 15 mul: low L bits of per-lane product when SIMD_MUL_EN is defined (REQ-029).
REQ-021 SHALL set sat_sticky on the cycle after the posedge on which a func 2/3 result with one or more clamped lanes is presented; it remains set until cleared.
REQ-022 clr_sat=1 SHALL clear sat_sticky at the next posedge, unless a clamping result is presented on that same cycle, which sets it (set wins).
REQ-023 Per-op state (operation, operands) SHALL travel with its pipeline slot; changing inputs while ops are in flight SHALL NOT affect them.

Reset
REQ-024 While rst=1 at a posedge: all pipeline valid bits, out_valid, sat_sticky SHALL become 0; res SHALL read zero.
REQ-025 Ops in flight at reset SHALL be discarded, never emerging; en during rst SHALL be ignored.
REQ-026 First op accepted at the first posedge with rst=0 SHALL emerge with the normal PIPE_DEPTH latency.
REQ-027 Data pipeline registers SHALL NOT require reset; only valid bits and sat_sticky are reset.

Configuration
REQ-028 Macro SIMD_MUL_EN SHALL select the multiplier.
REQ-029 With SIMD_MUL_EN defined: func 15 per REQ-020 for all lane sizes, never sets sat_sticky.
REQ-030 Without SIMD_MUL_EN: no multiplier logic; func 15 SHALL return R=0 with out_valid=1 and normal latency.

Verification
REQ-031 Lane 8 unsigned addsat, A=0x...F0 in every lane, B=0x20 in every lane -> every lane 0xFF, sat_sticky=1 the cycle after the result cycle.
REQ-032 Lane 16 signed subsat, lanes A=0x8000, B=0x0001 -> lanes 0x8000; then clr_sat with a non-saturating add -> sat_sticky=0.
REQ-033 Lane 32 add, A=0xFFFFFFFF_FFFFFFFF, B=1 in low lane only -> R=0xFFFFFFFF_00000000 (no inter-lane carry).
REQ-034 Lane 8 signed cmpgt, A lane=0x01, B lane=0xFF -> 0xFF; unsigned -> 0x00.
REQ-035 PIPE_DEPTH=3: en on 4 consecutive edges with a gap after op 2 -> results in order, one bubble, each at latency 3; rst asserted on the cycle after op 4 issued -> ops 3 and 4 never emerge.
REQ-036 func 15 lane 16, A=0x0102, B=0x0100 per lane -> 0x0200 per lane with SIMD_MUL_EN, R=0 without.
